unidade_controle_busca: RTL



---
 rtl/exp3_pkg.sv | 19 +
 rtl/unidade_controle_busca.sv | 99 +++++++++
 2 files changed

// File: rtl/exp3_pkg.sv
// Shared definitions for the experiment-3 linear-search circuit.
// Holds the controller state encoding and the default counter/switch width.
// Imported by the controller; the datapath only needs the width.
package exp3_pkg;

  localparam int W_DEF = 4;

  // Encodings are visible on db_estado, so they are fixed explicitly.
  typedef enum logic [3:0] {
    INICIAL   = 4'b0000,
    PREPARA   = 4'b0001,
    COMPARA   = 4'b0010,
    PROXIMO   = 4'b0011,
    ACHOU     = 4'b0100,
    NAO_ACHOU = 4'b0101,
    ESPERA    = 4'b0110
  } estado_t;

endpackage

// File: rtl/unidade_controle_busca.sv
// Purpose : Moore controller that sequences a counter/comparator datapath
//           through a linear search (clear, then compare/increment until a
//           match or until the count reaches 2^W-1).
// Latency : pronto pulses 2N+2 edges after the edge sampling iniciar, with
//           stable switches equal to N.
// Backpressure: none; iniciar/abortar are level-sampled every cycle.
//
// Ports:
//   clock, reset_n      - rising-edge clock, asynchronous active-low reset
//   iniciar, abortar    - start request / cancel search (level-sampled)
//   igual, contagem     - datapath comparator flag and current count
//   zera, conta         - datapath counter clear / increment controls
//   pronto, encontrado  - end-of-search pulse / held result flag
//   db_estado           - current state code for debug
module unidade_controle_busca
  import exp3_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         iniciar,
  input  logic         abortar,
  input  logic         igual,
  input  logic [W-1:0] contagem,
  output logic         zera,
  output logic         conta,
  output logic         pronto,
  output logic         encontrado,
  output logic [3:0]   db_estado
);

  localparam logic [W-1:0] ULTIMO = '1;

  estado_t estado_q, estado_d;
  logic    encontrado_q, encontrado_d;

  // State and result registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q     <= INICIAL;
      encontrado_q <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      encontrado_q <= encontrado_d;
    end
  end

  // Next-state logic. abortar is only honoured in the search loop.
  always_comb begin
    estado_d = INICIAL;
    unique case (estado_q)
      INICIAL:   estado_d = iniciar ? PREPARA : INICIAL;
      PREPARA:   estado_d = COMPARA;
      COMPARA: begin
        if (abortar)                estado_d = INICIAL;
        else if (igual)             estado_d = ACHOU;
        else if (contagem == ULTIMO) estado_d = NAO_ACHOU;
        else                        estado_d = PROXIMO;
      end
      PROXIMO:   estado_d = abortar ? INICIAL : COMPARA;
      ACHOU:     estado_d = ESPERA;
      NAO_ACHOU: estado_d = ESPERA;
      ESPERA:    estado_d = iniciar ? PREPARA : ESPERA;
      // Unused codes recover to the idle state.
      default:   estado_d = INICIAL;
    endcase
  end

  // Moore output decode, plus the result-register update. The result is
  // cleared when a new search is prepared and written when a search ends;
  // every other state holds it.
  always_comb begin
    zera         = 1'b0;
    conta        = 1'b0;
    pronto       = 1'b0;
    encontrado_d = encontrado_q;
    unique case (estado_q)
      PREPARA: begin
        zera         = 1'b1;
        encontrado_d = 1'b0;
      end
      PROXIMO:   conta = 1'b1;
      ACHOU: begin
        pronto       = 1'b1;
        encontrado_d = 1'b1;
      end
      NAO_ACHOU: begin
        pronto       = 1'b1;
        encontrado_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign encontrado = encontrado_q;
  assign db_estado  = estado_q;

endmodule
